// File: rtl/mult_pkg.sv
// Shared widths, latency constant and state encoding for the shift-add
// multiplier sequencer.
package mult_pkg;

    localparam int MUL_W   = 16;
    localparam int PROD_W  = 32;
    localparam int MUL_LAT = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/multi_16bit_seq.sv
// Valid/ready sequencer around the 16-bit shift-add multiplier: launches an
// operation, waits for done (or times out) and returns product minus baseline.
module multi_16bit_seq
    import mult_pkg::*;
#(
    parameter int TIMEOUT = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MUL_W-1:0]  in_a,
    input  logic [MUL_W-1:0]  in_b,
    output logic              mul_start,
    output logic [MUL_W-1:0]  mul_ain,
    output logic [MUL_W-1:0]  mul_bin,
    input  logic [PROD_W-1:0] mul_yout,
    input  logic              mul_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_y,
    output logic              out_err
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_OUT  = 2'(OUT);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MUL_W-1:0]  ain_q, ain_d;
    logic [MUL_W-1:0]  bin_q, bin_d;
    logic [PROD_W-1:0] base_q, base_d;
    logic [PROD_W-1:0] y_q, y_d;
    logic              err_q, err_d;

    // The multiplier only ever accumulates, so the product is the growth of
    // its register since launch; modular wrap keeps this exact.
    function automatic logic [PROD_W-1:0] wrap_diff(input logic [PROD_W-1:0] cur,
                                                    input logic [PROD_W-1:0] base);
        return cur - base;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        base_d  = base_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ain_d   = in_a;
                    bin_d   = in_b;
                    base_d  = mul_yout;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (mul_done) begin
                    y_d     = wrap_diff(mul_yout, base_q);
                    err_d   = 1'b0;
                    state_d = ST_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ain_q   <= '0;
            bin_q   <= '0;
            base_q  <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            base_q  <= base_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    // A timeout shorter than the nominal latency would abort good operations.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (TIMEOUT >= MUL_LAT + 2);
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign mul_start = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_OUT);
    assign mul_ain   = ain_q;
    assign mul_bin   = bin_q;
    assign out_y     = y_q;
    assign out_err   = err_q;

endmodule
